// File: rtl/idli_sqi_mem_m.sv
// ---------------------------------------------------------------------------
// idli_sqi_mem_m -- SQI memory responder (device end), sequential mode.
//
// Byte-wide RAM of 2^ADDR_W entries reached over a 4-bit SQI link. Every
// transaction begins with a command byte and a 16-bit address, both sent
// big-endian with the high nibble first:
//   0x02 write : data nibbles follow the address, high nibble first
//   0x03 read  : DUMMY_CYC dummy cycles, then data nibbles are returned
//   other      : the rest of the transaction is ignored
// The address auto-increments after every byte and wraps at 2^ADDR_W.
//
// Ports
//   i_sqi_gck     clock; every nibble is sampled or launched on its posedge
//   i_sqi_rst_n   asynchronous active-low reset
//   i_sqi_cs_n    chip select, active low, sampled on posedge
//   i_sqi_sio     nibble from initiator
//   o_sqi_sio     read-data nibble to initiator (registered)
//   o_sqi_sio_en  high while o_sqi_sio carries valid read data
// ---------------------------------------------------------------------------
module idli_sqi_mem_m #(
    parameter int ADDR_W    = 8,
    parameter int DUMMY_CYC = 2
) (
    input  logic       i_sqi_gck,
    input  logic       i_sqi_rst_n,
    input  logic       i_sqi_cs_n,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio,
    output logic       o_sqi_sio_en
);

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

    // Cycle numbers (counted from 0 at the first selected posedge) on which
    // the address phase and the dummy phase finish.
    localparam logic [7:0] CYC_ADDR_END  = 8'd5;
    localparam logic [7:0] CYC_DUMMY_END = 8'(5 + DUMMY_CYC);

    state_t              state_q, state_d;
    logic [7:0]          cyc_q, cyc_d;     // saturating transaction cycle count
    logic [ADDR_W-1:0]   a_q, a_d;         // current byte address
    logic [3:0]          nib_q, nib_d;     // held high nibble (command or write data)
    logic                ph_q, ph_d;       // 0: high nibble phase, 1: low nibble phase
    logic                rd_q, rd_d;       // command was a read
    logic                armed_q, armed_d; // a deselect was seen since reset
    logic [3:0]          sio_q, sio_d;
    logic                en_q, en_d;

    logic                wr_en;
    logic [7:0]          cmd_byte;
    logic [ADDR_W-1:0]   a_base;

    logic [7:0]          mem [2**ADDR_W];

    assign o_sqi_sio    = sio_q;
    assign o_sqi_sio_en = en_q;

    assign cmd_byte = {nib_q, i_sqi_sio};
    // The first address nibble starts from a clean register so nothing from
    // an earlier transaction leaks into the upper address bits.
    assign a_base   = (cyc_q == 8'd2) ? '0 : a_q;

    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_q <= S_CMD;
            cyc_q   <= '0;
            a_q     <= '0;
            nib_q   <= '0;
            ph_q    <= 1'b0;
            rd_q    <= 1'b0;
            armed_q <= 1'b0;
            sio_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            a_q     <= a_d;
            nib_q   <= nib_d;
            ph_q    <= ph_d;
            rd_q    <= rd_d;
            armed_q <= armed_d;
            sio_q   <= sio_d;
            en_q    <= en_d;
        end
    end

    // Array has no reset; its contents are undefined until written.
    always_ff @(posedge i_sqi_gck) begin
        if (wr_en) mem[a_q] <= {nib_q, i_sqi_sio};
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        a_d     = a_q;
        nib_d   = nib_q;
        ph_d    = ph_q;
        rd_d    = rd_q;
        armed_d = armed_q;
        sio_d   = '0;
        en_d    = 1'b0;
        wr_en   = 1'b0;

        if (i_sqi_cs_n) begin
            // Deselect ends any transaction; a half-written byte is dropped.
            state_d = S_CMD;
            cyc_d   = '0;
            ph_d    = 1'b0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            // A select still held across reset release stays ignored until
            // the initiator deselects and selects again.
            if (cyc_q != 8'hFF) cyc_d = cyc_q + 8'd1;

            unique case (state_q)
                S_CMD: begin
                    if (cyc_q[0] == 1'b0) begin
                        nib_d = i_sqi_sio;
                    end else if (cmd_byte == 8'h02 || cmd_byte == 8'h03) begin
                        rd_d    = (cmd_byte == 8'h03);
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end

                S_ADDR: begin
                    a_d = ADDR_W'({a_base, i_sqi_sio});
                    if (cyc_q == CYC_ADDR_END) begin
                        ph_d = 1'b0;
                        if (!rd_q) begin
                            state_d = S_WRITE;
                        end else if (DUMMY_CYC == 0) begin
                            state_d = S_READ;
                            sio_d   = mem[a_d][7:4];
                            en_d    = 1'b1;
                        end else begin
                            state_d = S_DUMMY;
                        end
                    end
                end

                S_DUMMY: begin
                    if (cyc_q == CYC_DUMMY_END) begin
                        state_d = S_READ;
                        ph_d    = 1'b0;
                        sio_d   = mem[a_q][7:4];
                        en_d    = 1'b1;
                    end
                end

                S_READ: begin
                    // High nibble is already on the pins; send the low nibble
                    // and step the address, then the next byte's high nibble.
                    en_d = 1'b1;
                    if (!ph_q) begin
                        sio_d = mem[a_q][3:0];
                        a_d   = a_q + 1'b1;
                        ph_d  = 1'b1;
                    end else begin
                        sio_d = mem[a_q][7:4];
                        ph_d  = 1'b0;
                    end
                end

                S_WRITE: begin
                    if (!ph_q) begin
                        nib_d = i_sqi_sio;
                        ph_d  = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        a_d   = a_q + 1'b1;
                        ph_d  = 1'b0;
                    end
                end

                S_IGNORE: begin
                end

                default: state_d = S_CMD;
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// ---------------------------------------------------------------------------
// tb_idli_sqi_mem_m -- self-checking bench for idli_sqi_mem_m.
// Each bus cycle pushes the expected {en, nibble} onto a scoreboard queue as
// the stimulus is driven; it is popped and compared after the posedge.
// Read expectations come from a shadow byte array updated by bench writes.
// ---------------------------------------------------------------------------
module tb_idli_sqi_mem_m;
    localparam int AW = 8;
    localparam int DC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic       sio_en;

    always #5 clk = ~clk;

    idli_sqi_mem_m #(.ADDR_W(AW), .DUMMY_CYC(DC)) dut (
        .i_sqi_gck   (clk),
        .i_sqi_rst_n (rst_n),
        .i_sqi_cs_n  (cs_n),
        .i_sqi_sio   (sio_i),
        .o_sqi_sio   (sio_o),
        .o_sqi_sio_en(sio_en)
    );

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        int          nb;
        logic [7:0]  d0;
        logic [7:0]  d1;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [4:0] sbq[$];
    logic [7:0] model[256];
    vec_t       vecs[6];

    function automatic void chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endfunction

    task automatic cyc(input logic cs, input logic [3:0] d, input logic een, input logic [3:0] enib);
        logic [4:0] e;
        @(negedge clk);
        cs_n  = cs;
        sio_i = d;
        sbq.push_back({een, enib});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sio_en", {7'd0, sio_en}, {7'd0, e[4]});
        if (e[4]) chk("sio", {4'd0, sio_o}, {4'd0, e[3:0]});
    endtask

    task automatic deselect();
        cyc(1'b1, 4'h0, 1'b0, 4'h0);
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [15:0] addr);
        cyc(1'b0, cmd[7:4], 1'b0, 4'h0);
        cyc(1'b0, cmd[3:0], 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) cyc(1'b0, addr[15-4*i -: 4], 1'b0, 4'h0);
    endtask

    task automatic do_write(input logic [15:0] addr, input int nb, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] b;
        logic [7:0] a;
        hdr(8'h02, addr);
        for (int k = 0; k < nb; k++) begin
            b = (k == 0) ? d0 : d1;
            a = addr[7:0] + 8'(k);
            cyc(1'b0, b[7:4], 1'b0, 4'h0);
            cyc(1'b0, b[3:0], 1'b0, 4'h0);
            model[a] = b;
        end
        deselect();
    endtask

    // Reads nb bytes but deselects after stop_after nibbles have appeared.
    task automatic do_read(input logic [15:0] addr, input int nb, input int stop_after);
        logic [3:0] nibs[$];
        logic [7:0] b;
        for (int k = 0; k < nb; k++) begin
            b = model[addr[7:0] + 8'(k)];
            nibs.push_back(b[7:4]);
            nibs.push_back(b[3:0]);
        end
        hdr(8'h03, addr);
        for (int i = 0; i < DC; i++) cyc(1'b0, 4'hF, (i == DC - 1), nibs[0]);
        for (int k = 1; k < 2 * nb && k < stop_after; k++) cyc(1'b0, 4'h0, 1'b1, nibs[k]);
        deselect();
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h0010, 2, 8'hA5, 8'h3C};
        vecs[1] = '{1'b1, 16'h0010, 2, 8'h00, 8'h00};
        vecs[2] = '{1'b0, 16'h00FF, 1, 8'h11, 8'h00};
        vecs[3] = '{1'b0, 16'h0000, 1, 8'h22, 8'h00};
        vecs[4] = '{1'b1, 16'h00FF, 2, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 16'h0020, 1, 8'h00, 8'h00};

        rst_n = 1'b0;
        cs_n  = 1'b1;
        sio_i = 4'h0;
        #12;
        chk("rst_en", {7'd0, sio_en}, 8'h00);
        chk("rst_sio", {4'd0, sio_o}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        deselect();

        // Write/read, wrap-around, and the zero seed for the partial-byte case.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rd) do_read(vecs[v].addr, vecs[v].nb, 99);
            else            do_write(vecs[v].addr, vecs[v].nb, vecs[v].d0, vecs[v].d1);
        end

        // Unknown command: the rest of the transaction is ignored.
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h5, 1'b0, 4'h0);
        repeat (8) cyc(1'b0, 4'hF, 1'b0, 4'h0);
        deselect();
        do_read(16'h0000, 1, 99);

        // Partial write byte dropped at deselect.
        hdr(8'h02, 16'h0020);
        cyc(1'b0, 4'h7, 1'b0, 4'h0);
        deselect();
        do_read(16'h0020, 1, 99);

        // Deselect right after the first read nibble, then a clean read.
        do_read(16'h0010, 2, 1);
        chk("desel_sio", {4'd0, sio_o}, 8'h00);
        do_read(16'h0010, 2, 99);

        // Reset while read data is on the pins: outputs clear without a clock.
        hdr(8'h03, 16'h0010);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b1, 4'hA);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rrd_en", {7'd0, sio_en}, 8'h00);
        chk("rrd_sio", {4'd0, sio_o}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        // Select still held after release: this write must be ignored.
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h2, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h1, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h7, 1'b0, 4'h0);
        cyc(1'b0, 4'h7, 1'b0, 4'h0);
        deselect();
        do_read(16'h0010, 1, 99);

        // Reset during the address phase, then a full write/read.
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h2, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        cyc(1'b0, 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("radr_en", {7'd0, sio_en}, 8'h00);
        chk("radr_sio", {4'd0, sio_o}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        deselect();
        do_write(16'h0001, 1, 8'h5A, 8'h00);
        do_read(16'h0001, 1, 99);

        chk("sbq_empty", 8'(sbq.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idli_sqi_mem_m.md
IDLI_SQI_MEM_M -- requirements
Module: idli_sqi_mem_m

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving log2 of the byte-array depth (2^ADDR_W bytes).
REQ-002 SHALL have parameter DUMMY_CYC, default 2, giving the number of read dummy nibble cycles.
REQ-003 SHALL have one clock and an asynchronous active-low reset: i_sqi_gck and i_sqi_rst_n.
REQ-004 SHALL have port i_sqi_gck  in  1  clock; every transfer nibble is sampled or launched on its posedge.
REQ-005 SHALL have port i_sqi_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port i_sqi_cs_n  in  1  chip select, active low, sampled on posedge.
REQ-007 SHALL have port i_sqi_sio  in  4  nibble from initiator.
REQ-008 SHALL have port o_sqi_sio  out  4  read-data nibble to initiator.
REQ-009 SHALL have port o_sqi_sio_en  out  1  high while o_sqi_sio carries valid read data.

Function
REQ-010 SHALL act as the SQI memory responder (device end) in sequential mode; all byte fields are big-endian, high nibble first.
REQ-011 SHALL count a transaction cycle on each posedge with i_sqi_cs_n low; the first such posedge after select is cycle 0.
REQ-012 SHALL run FSM states CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
REQ-013 SHALL capture the command byte in CMD over cycles 0-1.
REQ-014 SHALL leave CMD for ADDR on a command of 0x02 (write) or 0x03 (read).
REQ-015 SHALL leave CMD for IGNORE on any other command byte.
REQ-016 SHALL capture a 16-bit address in ADDR over cycles 2-5, MSB nibble first; only bits [ADDR_W-1:0] are used.
REQ-017 SHALL go from ADDR to WRITE after a write command and to DUMMY after a read command.
REQ-018 SHALL ignore i_sqi_sio for DUMMY_CYC cycles in DUMMY, then go to READ.
REQ-019 SHALL, at the posedge ending the last dummy cycle, register o_sqi_sio = mem[A][7:4] and o_sqi_sio_en = 1.
REQ-020 SHALL update o_sqi_sio to mem[A][3:0] on the next posedge, then mem[A+1][7:4], and so on.
REQ-021 SHALL, in WRITE, take the high nibble on one posedge and the low nibble on the next, writing mem[A] on the posedge that samples the low nibble.
REQ-022 SHALL increment A after each byte read or written, wrapping modulo 2^ADDR_W (0xFF -> 0x00 at the default).
REQ-023 SHALL treat i_sqi_cs_n high on a posedge as transaction end in any state: FSM -> CMD, cycle count -> 0, o_sqi_sio_en -> 0, o_sqi_sio -> 0.
REQ-024 SHALL discard a partial write byte (high nibble only) at deselect; memory stays unchanged.
REQ-025 SHALL, in IGNORE, keep o_sqi_sio_en at 0 and memory untouched until deselect.
REQ-026 SHALL require at least one posedge with i_sqi_cs_n high between transactions; re-select after that cycle starts a fresh cycle 0.
REQ-027 SHALL hold o_sqi_sio_en at 0 whenever the state is not READ.
REQ-028 SHALL read the memory array combinationally and write it synchronously; a read of the address just written returns the new data.

Reset
REQ-029 SHALL, on i_sqi_rst_n low, asynchronously force FSM = CMD, cycle count = 0, A = 0, o_sqi_sio = 0, o_sqi_sio_en = 0.
REQ-030 SHALL NOT reset the memory array; its contents are undefined until written.
REQ-031 SHALL, on reset asserted mid-transaction, abandon the transaction with no memory write, and SHALL require a fresh select after release.

Verification
REQ-032 Bench SHALL check write then read: write cmd 0x02, addr 0x0010, data 0xA5 0x3C; then read cmd 0x03, addr 0x0010 -> after 2 dummy cycles nibbles A,5,3,C with o_sqi_sio_en = 1.
REQ-033 Bench SHALL check wrap: write 0x11 at 0xFF and 0x22 at 0x00; read from 0x00FF for 2 bytes -> nibbles 1,1,2,2.
REQ-034 Bench SHALL check bad command: cmd 0x05 then 8 nibbles of 0xF -> o_sqi_sio_en stays 0 and a later read of address 0 is unchanged.
REQ-035 Bench SHALL check partial byte: write cmd, addr 0x0020, single nibble 0x7 then deselect -> mem[0x20] keeps its prior value 0x00.
REQ-036 Bench SHALL check mid-read deselect: during the READ of 0xA5, raise i_sqi_cs_n after nibble A -> o_sqi_sio_en = 0 on the next posedge and a new read starts cleanly.
REQ-037 Bench SHALL check async reset: assert i_sqi_rst_n low during ADDR -> outputs 0 immediately, and a subsequent full write/read of 0x5A at 0x0001 succeeds.
